nfu_1a_sched: RTL

NFU_1A_SCHED -- requirements
Module: nfu_1A_sched

---
 rtl/nfu_1a_sched_pkg.sv | 21 ++
 rtl/nfu_1a_sched_lane_pick.sv | 30 +++
 rtl/nfu_1a_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/nfu_1a_sched_pkg.sv
// Shared NFU-1A definitions: brick geometry, scheduler FSM encoding and the
// select-code mapping used by both the scheduler and the downstream mux stage.
package nfu_1a_sched_pkg;

  localparam int NFU_BIT_WIDTH = 16;
  localparam int NFU_TN        = 16;
  localparam int NFU_TNXTN     = NFU_TN * NFU_TN;
  localparam int NFU_D         = 3;
  localparam int NFU_SEL_WIDTH = 2;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

  // Position 0 (the current brick) maps to code d; candidate p maps to p-1.
  function automatic int sel_code(input int p, input int d);
    return (p == 0) ? d : p - 1;
  endfunction

endpackage

// File: rtl/nfu_1a_sched_lane_pick.sv
// One lane's priority encoder: lowest pending window position becomes the
// mux select, the lane-valid flag and a one-hot clear mask.
module nfu_1a_lane_pick
  import nfu_1a_sched_pkg::*;
#(
  parameter int D         = NFU_D,
  parameter int SEL_WIDTH = NFU_SEL_WIDTH
) (
  input  logic [D:0]           pend,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 lane_vld,
  output logic [D:0]           clr
);

  always_comb begin
    sel      = SEL_WIDTH'(D);
    lane_vld = 1'b0;
    clr      = '0;
    // Scan high to low so the lowest pending position wins.
    for (int p = D; p >= 0; p--) begin
      if (pend[p]) begin
        sel      = SEL_WIDTH'(sel_code(p, D));
        lane_vld = 1'b1;
        clr      = '0;
        clr[p]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nfu_1a_sched.sv
// NFU-1A zero-skipping scheduler: collects a window of D+1 bricks, then drains
// one beat per remaining nonzero value in the busiest lane.
module nfu_1a_sched
  import nfu_1a_sched_pkg::*;
#(
  parameter int BIT_WIDTH = NFU_BIT_WIDTH,
  parameter int Tn        = NFU_TN,
  parameter int TnxTn     = NFU_TNXTN,
  parameter int D         = NFU_D,
  parameter int SEL_WIDTH = NFU_SEL_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BIT_WIDTH*Tn-1:0]    i_brick,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [BIT_WIDTH*Tn-1:0]    o_cur_inputs,
  output logic [BIT_WIDTH*Tn*D-1:0]  o_repl_cands,
  output logic [SEL_WIDTH*TnxTn-1:0] o_sel_lines,
  output logic [Tn-1:0]              o_lane_vld,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_last,
  output logic [15:0]                o_skip_cnt
);

  localparam int FCNT_W = (D > 0) ? $clog2(D + 1) : 1;
  localparam logic [SEL_WIDTH-1:0] SEL_IDLE = SEL_WIDTH'(D);

  sched_state_t state, state_nxt;
  logic [FCNT_W-1:0]    fcnt;
  logic [15:0]          skip_cnt;
  logic [D:0]           pend      [Tn];
  logic [D:0]           pend_left [Tn];
  logic [D:0]           lane_clr  [Tn];
  logic [SEL_WIDTH-1:0] lane_sel  [Tn];
  logic [BIT_WIDTH-1:0] win       [D+1][Tn];
  logic [Tn-1:0]        lane_vld;
  logic [Tn-1:0]        brick_nz;
  logic                 load, fill_end, active, fire, any_pend, win_last;

  assign o_ready  = (state == FILL) && !rst;
  assign active   = (state == DRAIN) && !rst;
  assign load     = o_ready && i_valid;
  assign fill_end = load && (fcnt == FCNT_W'(D));
  assign fire     = active && i_ready;

  for (genvar l = 0; l < Tn; l++) begin : g_lane
    nfu_1a_lane_pick #(
      .D         (D),
      .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
      .pend     (pend[l]),
      .sel      (lane_sel[l]),
      .lane_vld (lane_vld[l]),
      .clr      (lane_clr[l])
    );
    assign pend_left[l] = pend[l] & ~lane_clr[l];
  end

  always_comb begin
    brick_nz = '0;
    any_pend = 1'b0;
    win_last = 1'b1;
    for (int l = 0; l < Tn; l++) begin
      brick_nz[l] = (i_brick[l*BIT_WIDTH +: BIT_WIDTH] != '0);
      any_pend    = any_pend | brick_nz[l] | (|pend[l]);
      if (pend_left[l] != '0) win_last = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (fill_end && any_pend) state_nxt = DRAIN;
      DRAIN:   if (fire && win_last) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Window capture, pending-bit bookkeeping and skip counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt     <= '0;
      skip_cnt <= '0;
      for (int l = 0; l < Tn; l++) begin
        pend[l] <= '0;
        for (int p = 0; p <= D; p++) win[p][l] <= '0;
      end
    end else if (load) begin
      for (int l = 0; l < Tn; l++) begin
        win[fcnt][l]  <= i_brick[l*BIT_WIDTH +: BIT_WIDTH];
        pend[l][fcnt] <= brick_nz[l];
      end
      if (fill_end) begin
        fcnt <= '0;
        if (!any_pend) skip_cnt <= skip_cnt + 16'd1;
      end else begin
        fcnt <= fcnt + FCNT_W'(1);
      end
    end else if (fire) begin
      for (int l = 0; l < Tn; l++) pend[l] <= pend_left[l];
    end
  end

  // Output beat: everything idles to zero / select D outside an active drain.
  always_comb begin
    o_cur_inputs = '0;
    o_repl_cands = '0;
    o_sel_lines  = {TnxTn{SEL_IDLE}};
    for (int l = 0; l < Tn; l++) begin
      if (active) begin
        if (lane_vld[l]) o_cur_inputs[l*BIT_WIDTH +: BIT_WIDTH] = win[0][l];
        for (int d = 0; d < D; d++)
          o_repl_cands[(l*D+d)*BIT_WIDTH +: BIT_WIDTH] = win[d+1][l];
        for (int m = 0; m < Tn; m++)
          o_sel_lines[(l*Tn+m)*SEL_WIDTH +: SEL_WIDTH] = lane_sel[l];
      end
    end
  end

  assign o_valid    = active;
  assign o_last     = active && win_last;
  assign o_lane_vld = active ? lane_vld : '0;
  assign o_skip_cnt = skip_cnt;

endmodule
